stream_mux_arb: RTL

STREAM_MUX_ARB -- requirements
Module: stream_mux_arb

---
 rtl/stream_mux_arb.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/stream_mux_arb.sv
// stream_mux_arb: N-channel packet stream mux with fixed, round-robin and
// forced arbitration, packet locking and a single registered output stage.
module stream_mux_arb #(
   parameter  int NCH = 4,
   parameter  int W   = 8,
   localparam int SW  = $clog2(NCH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [NCH*W-1:0] in_data,
   input  logic [NCH-1:0]   in_valid,
   input  logic [NCH-1:0]   in_last,
   output logic [NCH-1:0]   in_ready,
   input  logic [1:0]       mode,
   input  logic [SW-1:0]    force_sel,
   output logic [W-1:0]     out_data,
   output logic             out_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [SW-1:0]    out_sel,
   output logic             busy
);

   typedef enum logic {
      S_IDLE   = 1'b0,
      S_LOCKED = 1'b1
   } state_t;

   state_t          r_state;
   state_t          w_state_nxt;
   logic [SW-1:0]   r_g;
   logic [SW-1:0]   r_rr;
   logic            r_pkt_rr;
   logic [W-1:0]    r_out_data;
   logic            r_out_last;
   logic            r_out_valid;
   logic [SW-1:0]   r_out_sel;

   logic [SW-1:0]   w_cand;
   logic            w_cand_vld;
   logic [SW-1:0]   w_act;
   logic            w_act_vld;
   logic            w_load_en;
   logic [W-1:0]    w_data;
   logic            w_last;
   logic            w_vsel;
   logic            w_acc;
   logic            w_rr_mode;
   logic [SW-1:0]   w_rr_nxt;

   assign w_load_en = !r_out_valid || out_ready;
   assign w_act     = (r_state == S_LOCKED) ? r_g : w_cand;
   assign w_act_vld = (r_state == S_LOCKED) || w_cand_vld;
   assign w_acc     = rst_n && w_load_en && w_act_vld && w_vsel;
   assign w_rr_mode = (r_state == S_LOCKED) ? r_pkt_rr : (mode == 2'b01);
   assign w_rr_nxt  = (w_act == SW'(NCH-1)) ? '0 : w_act + SW'(1);

   // idle-time candidate according to the arbitration mode
   always_comb begin
      int best;
      int d;
      best       = NCH;
      d          = 0;
      w_cand     = '0;
      w_cand_vld = 1'b0;
      case (mode)
         2'b01: begin
            for (int i = 0; i < NCH; i++) begin
               d = (i + NCH - int'(r_rr)) % NCH;
               if (in_valid[i] && d < best) begin
                  best       = d;
                  w_cand     = SW'(i);
                  w_cand_vld = 1'b1;
               end
            end
         end
         2'b10: begin
            for (int i = 0; i < NCH; i++) begin
               if (SW'(i) == force_sel && in_valid[i]) begin
                  w_cand     = SW'(i);
                  w_cand_vld = 1'b1;
               end
            end
         end
         default: begin
            for (int i = NCH - 1; i >= 0; i--) begin
               if (in_valid[i]) begin
                  w_cand     = SW'(i);
                  w_cand_vld = 1'b1;
               end
            end
         end
      endcase
   end

   // route the active channel's beat toward the output register
   always_comb begin
      w_data = '0;
      w_last = 1'b0;
      w_vsel = 1'b0;
      for (int i = 0; i < NCH; i++) begin
         if (SW'(i) == w_act) begin
            w_data = in_data[i*W +: W];
            w_last = in_last[i];
            w_vsel = in_valid[i];
         end
      end
   end

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   // FSM next state: lock on a non-last first beat, free on a last beat
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:   if (w_acc && !w_last) w_state_nxt = S_LOCKED;
         S_LOCKED: if (w_acc && w_last)  w_state_nxt = S_IDLE;
         default:  w_state_nxt = S_IDLE;
      endcase
   end

   // FSM outputs: handshake toward the active channel only
   always_comb begin
      in_ready = '0;
      busy     = (r_state == S_LOCKED);
      for (int i = 0; i < NCH; i++) begin
         if (rst_n && w_load_en && w_act_vld && SW'(i) == w_act)
            in_ready[i] = 1'b1;
      end
   end

   // grant and round-robin pointer bookkeeping
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_g      <= '0;
         r_rr     <= '0;
         r_pkt_rr <= 1'b0;
      end else if (w_acc) begin
         if (r_state == S_IDLE) begin
            r_g      <= w_cand;
            r_pkt_rr <= (mode == 2'b01);
         end
         if (w_last && w_rr_mode) r_rr <= w_rr_nxt;
      end
   end

   // output register, loads only when empty or being drained
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_data  <= '0;
         r_out_last  <= 1'b0;
         r_out_valid <= 1'b0;
         r_out_sel   <= '0;
      end else if (w_load_en) begin
         r_out_valid <= w_acc;
         if (w_acc) begin
            r_out_data <= w_data;
            r_out_last <= w_last;
            r_out_sel  <= w_act;
         end
      end
   end

   assign out_data  = r_out_data;
   assign out_last  = r_out_last;
   assign out_valid = r_out_valid;
   assign out_sel   = r_out_sel;

endmodule
